// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over a req/ack handshake and buffers {pc, inst} for IF_ID.
// Redirects flush the buffer; a request still in flight at redirect has its reply dropped.
module fetch_unit #(
   parameter logic [31:0] ResetPC   = 32'h0000_0000,
   parameter int          FifoDepth = 2,
   parameter logic [31:0] NopInst   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        stall,
   input  logic        redirectValid,
   input  logic [31:0] redirectPC,
   output logic        instValid,
   output logic [31:0] instOut,
   output logic [31:0] pcOut
);
   localparam int PW = $clog2(FifoDepth);
   localparam int CW = $clog2(FifoDepth + 1);
   localparam logic [PW-1:0] LAST = PW'(FifoDepth - 1);
   localparam logic [CW-1:0] FULL = CW'(FifoDepth);

   typedef enum logic {IDLE, FETCH} state_t;

   state_t         state;
   logic [31:0]    pc;
   logic           discard;
   logic [CW-1:0]  count;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [31:0]    fifo_pc   [FifoDepth];
   logic [31:0]    fifo_inst [FifoDepth];
   logic           fire;
   logic           push;
   logic           pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Request stays up while a discarded reply is still owed, even with a full buffer.
   assign imemReq   = (state == FETCH) && ((count < FULL) || discard);
   assign imemAddr  = pc;
   assign fire      = imemReq && imemAck;
   assign push      = fire && !discard && !redirectValid;
   assign pop       = instValid && !stall && !redirectValid;
   assign instValid = (count != '0);
   assign instOut   = instValid ? fifo_inst[rd_ptr] : NopInst;
   assign pcOut     = instValid ? fifo_pc[rd_ptr] : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= ResetPC;
         discard <= 1'b0;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
      end else begin
         state <= FETCH;
         if (redirectValid) begin
            pc      <= {redirectPC[31:2], 2'b00};
            discard <= imemReq && !imemAck;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
         end else begin
            if (fire) discard <= 1'b0;
            if (push) begin
               pc     <= pc + 32'd4;
               wr_ptr <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= pc;
         fifo_inst[wr_ptr] <= imemData;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of expected PCs popped as IF_ID consumes entries.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic        stall = 1'b0;
   logic        redirectValid = 1'b0;
   logic [31:0] redirectPC = 32'h0;
   logic        instValid;
   logic [31:0] instOut;
   logic [31:0] pcOut;

   int          lat = 0;
   int          wcnt = 0;
   logic        ack_en = 1'b1;
   logic        ack_force = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] q[$];
   logic [31:0] mon_exp;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
      .imemData(imemData), .stall(stall), .redirectValid(redirectValid), .redirectPC(redirectPC),
      .instValid(instValid), .instOut(instOut), .pcOut(pcOut)
   );

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5C3, ~a[31:16]};
   endfunction

   always #5 clk = ~clk;

   // Memory model: acks once a request has waited lat cycles.
   assign imemData = pat(imemAddr);
   assign imemAck  = ack_force || (ack_en && imemReq && wcnt >= lat);
   always @(posedge clk) wcnt <= (!rst_n || (imemReq && imemAck)) ? 0 : imemReq ? wcnt + 1 : wcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && instValid && !stall && !redirectValid) begin
         if (q.size() != 0) mon_exp = q.pop_front();
         else mon_exp = 32'hDEAD_BEEF;
         chk("sb_pc", pcOut, mon_exp);
         chk("sb_inst", instOut, pat(mon_exp));
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, imemReq, 0);
      chk({tag, "_addr"}, imemAddr, 0);
      chk({tag, "_valid"}, instValid, 0);
      chk({tag, "_inst"}, instOut, 32'h13);
      chk({tag, "_pc"}, pcOut, 0);
   endtask

   task automatic do_reset(input logic st);
      @(posedge clk); #1;
      rst_n = 1'b0; stall = st; redirectValid = 1'b0; ack_force = 1'b0; q.delete();
      #1 chk_reset("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      int i = 0;
      while (q.size() != 0 && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      chk(tag, q.size(), 0);
      stall = 1'b1;
   endtask

   task automatic wait_addr(input logic [31:0] a);
      int i = 0;
      while (!(imemReq && imemAddr == a) && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      chk("wait_addr", imemAddr, a);
   endtask

   initial begin
      // Ack tied high: one fetch per cycle.
      lat = 0;
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(32'(i * 4));
      @(negedge clk); chk("p1_idle_req", imemReq, 0);
      @(negedge clk); chk("p1_req", imemReq, 1); chk("p1_addr0", imemAddr, 0); chk("p1_valid0", instValid, 0);
      @(negedge clk); chk("p1_addr4", imemAddr, 4); chk("p1_valid1", instValid, 1);
      @(negedge clk); chk("p1_addr8", imemAddr, 8);
      drain("p1_drain");

      // Two-cycle ack latency: address held while waiting.
      lat = 2;
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) q.push_back(32'(i * 4));
      @(negedge clk);
      @(negedge clk); chk("p2_w0", imemAddr, 0); chk("p2_req0", imemReq, 1);
      @(negedge clk); chk("p2_w1", imemAddr, 0); chk("p2_req1", imemReq, 1);
      @(negedge clk); chk("p2_w2", imemAddr, 0); chk("p2_valid_d", instValid, 0);
      @(negedge clk); chk("p2_addr4", imemAddr, 4); chk("p2_valid_e", instValid, 1);
      drain("p2_drain");

      // Stall fills the FIFO, then the request drops.
      lat = 0;
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) q.push_back(32'(i * 4));
      repeat (6) @(negedge clk);
      chk("p3_req_full", imemReq, 0); chk("p3_addr", imemAddr, 8);
      chk("p3_valid", instValid, 1); chk("p3_head", pcOut, 0);
      @(posedge clk); #1 stall = 1'b0;
      @(negedge clk); chk("p3_req_still0", imemReq, 0);
      @(negedge clk); chk("p3_req_back", imemReq, 1);
      drain("p3_drain");

      // Redirect while the request to 0x8 is waiting.
      lat = 2;
      do_reset(1'b0);
      q.push_back(32'h0);
      wait_addr(32'h8);
      chk("p4_pre", q.size(), 0);
      q.push_back(32'h100); q.push_back(32'h104); q.push_back(32'h108);
      redirectValid = 1'b1; redirectPC = 32'h100;
      @(posedge clk); #1 redirectValid = 1'b0;
      @(negedge clk); chk("p4_valid", instValid, 0); chk("p4_addr", imemAddr, 32'h100); chk("p4_req", imemReq, 1);
      drain("p4_drain");

      // Redirect coinciding with the ack for 0xC; low target bits ignored.
      lat = 0;
      do_reset(1'b0);
      q.push_back(32'h0); q.push_back(32'h4);
      wait_addr(32'hC);
      chk("p5_pre", q.size(), 0);
      q.push_back(32'h40); q.push_back(32'h44); q.push_back(32'h48);
      redirectValid = 1'b1; redirectPC = 32'h42;
      @(posedge clk); #1 redirectValid = 1'b0;
      @(negedge clk); chk("p5_valid", instValid, 0); chk("p5_addr", imemAddr, 32'h40); chk("p5_req", imemReq, 1);
      drain("p5_drain");

      // Reset in the middle of a wait for 0x20.
      lat = 0;
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(32'(i * 4));
      wait_addr(32'h20);
      ack_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("p6_q", q.size(), 0); chk("p6_req", imemReq, 1); chk("p6_addr", imemAddr, 32'h20); chk("p6_valid", instValid, 0);
      @(posedge clk); #1;
      rst_n = 1'b0; ack_force = 1'b1; ack_en = 1'b1;
      #1 chk_reset("p6_rst");
      @(posedge clk); #1 chk_reset("p6_rst_edge");
      ack_force = 1'b0;
      q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8);
      rst_n = 1'b1;
      @(negedge clk); chk("p6_idle", imemReq, 0);
      @(negedge clk); chk("p6_restart", imemAddr, 0); chk("p6_req2", imemReq, 1);
      drain("p6_drain");

      // PC wraps from 0xFFFFFFFC to 0.
      lat = 0;
      do_reset(1'b0);
      redirectValid = 1'b1; redirectPC = 32'hFFFF_FFF8;
      q.push_back(32'hFFFF_FFF8); q.push_back(32'hFFFF_FFFC); q.push_back(32'h0); q.push_back(32'h4);
      @(posedge clk); #1 redirectValid = 1'b0;
      chk("p7_addr", imemAddr, 32'hFFFF_FFF8);
      drain("p7_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the IF_ID register and instruction decoder.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {pc, inst} to IF_ID with a valid flag.
- Honours pipeline stall, and branch/JAL redirect from the ALU/branch unit.

Parameters:
- ResetPC, 32'h00000000, PC value loaded at reset.
- FifoDepth, 2, number of {pc, inst} entries buffered (legal values 2..4).
- NopInst, 32'h00000013, instruction driven on instOut when no valid entry (ADDI x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imemReq  output  1  fetch request to instruction memory.
- imemAddr  output  32  word address of the request; stable while imemReq=1 and imemAck=0.
- imemAck  input  1  memory accepts and completes the request this cycle.
- imemData  input  32  instruction word, valid when imemReq&&imemAck.
- stall  input  1  downstream hazard; head entry must not be consumed.
- redirectValid  input  1  taken branch/jump this cycle.
- redirectPC  input  32  new PC target, valid with redirectValid.
- instValid  output  1  instOut/pcOut hold a real instruction.
- instOut  output  32  instruction to IF_ID; NopInst when instValid=0.
- pcOut  output  32  PC of instOut; 0 when instValid=0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=ResetPC, state=IDLE, FIFO count=0, discard=0.
  - imemReq=0, imemAddr=ResetPC, instValid=0, instOut=NopInst, pcOut=0.
- State machine:
  - IDLE -> FETCH unconditionally on the first edge after reset release.
  - In FETCH, imemReq=(count<FifoDepth)||discard and imemAddr=pc.
  - There is no other state; at most one request is outstanding.
- Handshake:
  - A transfer completes on any cycle with imemReq&&imemAck; memory may ack in the same cycle as the request or any later cycle.
  - Once imemReq rises it stays high with imemAddr constant until the ack arrives. Count cannot rise without an ack, so the request is never withdrawn.
- Accepted transfer (discard=0, no redirect this cycle):
  - Push {pc, imemData} into the FIFO.
  - pc <= pc+4, modulo 2^32; 32'hFFFFFFFC wraps to 0.
- Output:
  - FIFO head is driven on instOut/pcOut; instValid=(count!=0).
  - Pop occurs when instValid && !stall && !redirectValid.
  - Push and pop in the same cycle leave count unchanged.
  - A push into a full FIFO cannot occur because imemReq is low when count=FifoDepth.
- Redirect (redirectValid=1), which has priority over stall and over any push:
  - FIFO flushed (count=0) on the same edge; instValid=0 from the next cycle.
  - pc <= redirectPC.
  - If a request is outstanding and not acked this cycle, set discard=1.
  - If the ack coincides with the redirect, the data is dropped and discard stays 0.
- discard=1:
  - The next ack's data is dropped, pc is not incremented, and discard clears.
  - The new request to redirectPC is raised on the following cycle.
  - A second redirect while discard=1 only updates pc; discard remains 1.
- Stall without redirect: the head is held and the FIFO keeps filling until full, then imemReq deasserts. imemReq reasserts in the cycle after a pop makes count<FifoDepth.
- redirectPC[1:0] is ignored and forced to 0.
- Reset asserted mid-operation aborts any outstanding request immediately; an ack arriving during reset is ignored.

Test Plan:
- Reset release, imemAck tied 1, imemData=pc-based pattern -> imemAddr 0,4,8,... one per cycle; instValid from cycle 2; pcOut follows 0,4,8 with matching instOut.
- Ack latency 2 cycles -> imemAddr held stable during wait; one instruction per 3 cycles; no duplicates or gaps.
- stall=1 for 6 cycles with ack=1 -> FIFO holds pc 0,4, then imemReq=0; release stall -> pcOut 0,4,8 in order with no loss.
- redirectValid with redirectPC=0x100 while request to 0x8 outstanding, ack 2 cycles later -> 0x8 data dropped, next imemAddr=0x100, first valid pcOut=0x100.
- Redirect same cycle as ack for 0xC, redirectPC=0x40 -> 0xC never appears, FIFO empty next cycle, imemAddr=0x40.
- rst_n low mid-wait with pc=0x20 -> outputs return to reset values immediately; after release, fetch restarts at ResetPC.
